// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the 7-segment scan sequencer: FSM states,
// dark-output constants, the hex segment table and the digit search helper.
package scan_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [7:0] ANODE_OFF = 8'hFF;
    localparam logic [6:0] SEG_DARK  = 7'h7F;

    // Segment patterns {g,f,e,d,c,b,a}, active-low; element n is hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // First enabled digit at or above start, searching upward mod 8.
    // Returns start when the mask is empty.
    function automatic logic [2:0] first_enabled(input logic [7:0] mask,
                                                 input logic [2:0] start);
        logic [2:0] k;
        logic [2:0] hit;
        hit = start;
        // Walk offsets high to low so the smallest enabled offset wins.
        for (int unsigned i = 8; i > 0; i--) begin
            k = start + 3'(i - 1);
            if (mask[k]) hit = k;
        end
        return hit;
    endfunction

endpackage

// File: rtl/scan_sequencer_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
    import scan_sequencer_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Each slot is a blanking gap followed by a PWM-dimmed drive phase; only
// digits enabled in digit_en are visited.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int unsigned SLOT_CYC  = 16384,
    parameter int unsigned BLANK_CYC = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp,
    input  logic [3:0]  brightness,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    localparam int unsigned     SLOT_W     = $clog2(SLOT_CYC);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic [3:0]          r_pwm;
    logic [2:0]          r_idx;
    logic [3:0]          r_nibble;
    logic                r_dp;
    logic [7:0]          r_anode;
    logic [6:0]          r_seg;
    logic                r_dp_n;
    logic                r_frame_done;

    logic                w_run;
    logic [2:0]          w_entry_idx;
    logic [2:0]          w_next_idx;
    logic [3:0]          w_pwm_next;
    logic [7:0]          w_lit_anode;
    logic [6:0]          w_seg;

    // Scanning needs both the global enable and at least one enabled digit.
    assign w_run       = enable && (digit_en != '0);
    // From OFF the current digit is kept if still enabled.
    assign w_entry_idx = first_enabled(digit_en, r_idx);
    // At slot end the current digit is only revisited if it is the sole one.
    assign w_next_idx  = first_enabled(digit_en, r_idx + 3'd1);
    assign w_pwm_next  = r_pwm + 4'd1;
    assign w_lit_anode = ~(8'd1 << r_idx);

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (r_nibble),
        .o_seg    (w_seg)
    );

    // Scan FSM with slot/PWM counters and registered display outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_OFF;
            r_slot       <= '0;
            r_pwm        <= '0;
            r_idx        <= '0;
            r_nibble     <= '0;
            r_dp         <= 1'b0;
            r_anode      <= ANODE_OFF;
            r_seg        <= SEG_DARK;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (!w_run) begin
                r_state <= ST_OFF;
                r_slot  <= '0;
                r_pwm   <= '0;
                r_anode <= ANODE_OFF;
                r_seg   <= SEG_DARK;
                r_dp_n  <= 1'b1;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state  <= ST_BLANK;
                        r_slot   <= '0;
                        r_idx    <= w_entry_idx;
                        r_nibble <= value[{w_entry_idx, 2'b00} +: 4];
                        r_dp     <= dp[w_entry_idx];
                        r_anode  <= ANODE_OFF;
                        r_seg    <= SEG_DARK;
                        r_dp_n   <= 1'b1;
                    end
                    ST_BLANK: begin
                        r_slot <= r_slot + 1'b1;
                        if (r_slot == BLANK_LAST) begin
                            r_state <= ST_DRIVE;
                            r_pwm   <= '0;
                            if (brightness != 4'd0) begin
                                r_anode <= w_lit_anode;
                                r_seg   <= w_seg;
                                r_dp_n  <= ~r_dp;
                            end else begin
                                r_anode <= ANODE_OFF;
                                r_seg   <= SEG_DARK;
                                r_dp_n  <= 1'b1;
                            end
                        end else begin
                            r_anode <= ANODE_OFF;
                            r_seg   <= SEG_DARK;
                            r_dp_n  <= 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        if (r_slot == SLOT_LAST) begin
                            r_state      <= ST_BLANK;
                            r_slot       <= '0;
                            r_idx        <= w_next_idx;
                            r_nibble     <= value[{w_next_idx, 2'b00} +: 4];
                            r_dp         <= dp[w_next_idx];
                            r_frame_done <= (w_next_idx <= r_idx);
                            r_anode      <= ANODE_OFF;
                            r_seg        <= SEG_DARK;
                            r_dp_n       <= 1'b1;
                        end else begin
                            r_slot <= r_slot + 1'b1;
                            r_pwm  <= w_pwm_next;
                            if (w_pwm_next < brightness) begin
                                r_anode <= w_lit_anode;
                                r_seg   <= w_seg;
                                r_dp_n  <= ~r_dp;
                            end else begin
                                r_anode <= ANODE_OFF;
                                r_seg   <= SEG_DARK;
                                r_dp_n  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_anode <= ANODE_OFF;
                        r_seg   <= SEG_DARK;
                        r_dp_n  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign anode      = r_anode;
    assign seg        = r_seg;
    assign dp_n       = r_dp_n;
    assign digit_idx  = r_idx;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer with a slot-time reference model.
module tb_scan_sequencer;

    localparam int SLOT  = 32;
    localparam int BLANK = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  dp = '0;
    logic [3:0]  brightness = '0;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp_n;
    logic [2:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int fails  = 0;

    scan_sequencer #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .digit_en   (digit_en),
        .dp         (dp),
        .brightness (brightness),
        .anode      (anode),
        .seg        (seg),
        .dp_n       (dp_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    // Reference model: time since slot start, current digit and latched data.
    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    bit         m_active = 0;
    int         m_t = 0;
    int         m_idx = 0;
    int         m_old = 0;
    logic [3:0] m_nib = '0;
    logic       m_dp = 1'b0;
    logic [7:0] e_anode = 8'hFF;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dpn = 1'b1;
    logic [2:0] e_idx = '0;
    logic       e_fd = 1'b0;

    logic [19:0] w_obs, w_exp;
    assign w_obs = {anode, seg, dp_n, digit_idx, frame_done};
    assign w_exp = {e_anode, e_seg, e_dpn, e_idx, e_fd};

    function automatic int search(int start, int first_off, logic [7:0] m);
        for (int off = first_off; off < first_off + 8; off++)
            if (m[(start + off) % 8]) return (start + off) % 8;
        return start;
    endfunction

    always @(posedge clock or posedge reset) begin
        e_fd = 1'b0;
        if (reset) begin
            m_active = 0;
            m_idx = 0;
        end else if (!enable || digit_en == 8'h00) begin
            m_active = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_idx = search(m_idx, 0, digit_en);
            m_t = 0;
            m_nib = value[m_idx*4 +: 4];
            m_dp = dp[m_idx];
        end else begin
            m_t++;
            if (m_t == SLOT) begin
                m_old = m_idx;
                m_idx = search(m_idx, 1, digit_en);
                e_fd = (m_idx <= m_old);
                m_t = 0;
                m_nib = value[m_idx*4 +: 4];
                m_dp = dp[m_idx];
            end
        end
        if (m_active && m_t >= BLANK && ((m_t - BLANK) % 16) < int'(brightness)) begin
            e_anode = ~(8'd1 << m_idx);
            e_seg = seg_ref[m_nib];
            e_dpn = ~m_dp;
        end else begin
            e_anode = 8'hFF;
            e_seg = 7'h7F;
            e_dpn = 1'b1;
        end
        e_idx = 3'(m_idx);
    end

    function automatic string obs_str();
        return $sformatf("got an=%h seg=%h dpn=%b idx=%0d fd=%b, want an=%h seg=%h dpn=%b idx=%0d fd=%b",
                         anode, seg, dp_n, digit_idx, frame_done,
                         e_anode, e_seg, e_dpn, e_idx, e_fd);
    endfunction

    task automatic test_reset();
        #12;
        checks++; if (anode !== 8'hFF) begin fails++; $display("FAIL reset_anode got %h want ff", anode); end
        checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h want 7f", seg); end
        checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dpn got %b want 1", dp_n); end
        checks++; if (digit_idx !== 3'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", digit_idx); end
        checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got %b want 0", frame_done); end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_walk();
        int  fd_cnt = 0;
        bit  seen0 = 0;
        enable = 1'b1; digit_en = 8'hFF; brightness = 4'hF;
        value = 32'h76543210; dp = 8'($urandom);
        for (int c = 0; c < 600; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL walk_model @%0t %s", $time, obs_str()); end
            if (anode == 8'hFE) begin
                seen0 = 1;
                checks++; if (seg !== 7'h40) begin fails++; $display("FAIL walk_seg_d0 got %h want 40", seg); end
            end
            if (anode == 8'hF7) begin
                checks++; if (seg !== 7'h30) begin fails++; $display("FAIL walk_seg_d3 got %h want 30", seg); end
            end
            if (c >= 88 && frame_done) fd_cnt++;
        end
        checks++; if (!seen0) begin fails++; $display("FAIL walk_lit_d0 got never-lit want lit"); end
        checks++; if (fd_cnt != 2) begin fails++; $display("FAIL walk_frames got %0d want 2", fd_cnt); end
    endtask

    task automatic test_mask_skip();
        int         fd_cnt = 0;
        logic [7:0] seen = '0;
        digit_en = 8'b1000_0101;
        for (int c = 0; c < 288; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL skip_model @%0t %s", $time, obs_str()); end
            if (c >= 96) begin
                if (frame_done) fd_cnt++;
                if (anode != 8'hFF) seen = seen | ~anode;
            end
        end
        checks++; if (fd_cnt != 2) begin fails++; $display("FAIL skip_frames got %0d want 2", fd_cnt); end
        checks++; if (seen !== 8'h85) begin fails++; $display("FAIL skip_digits got %h want 85", seen); end
    endtask

    task automatic test_pwm();
        int lit = 0;
        int fd_cnt = 0;
        bit any_lit = 0;
        digit_en = 8'h01; brightness = 4'd4;
        for (int c = 0; c < 128; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL pwm_model @%0t %s", $time, obs_str()); end
            if (c >= 64) begin
                if (frame_done) fd_cnt++;
                if (c < 96 && anode != 8'hFF) lit++;
            end
        end
        checks++; if (lit != 8) begin fails++; $display("FAIL pwm_lit got %0d want 8", lit); end
        checks++; if (fd_cnt != 2) begin fails++; $display("FAIL pwm_frames got %0d want 2", fd_cnt); end
        brightness = 4'd0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL pwm0_model @%0t %s", $time, obs_str()); end
            if (anode != 8'hFF) any_lit = 1;
        end
        checks++; if (any_lit) begin fails++; $display("FAIL pwm0_dark got lit want ff"); end
    endtask

    task automatic test_value_latch();
        bit found = 0;
        digit_en = 8'hFF; brightness = 4'hF; value = '0; dp = '0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL latch_model @%0t %s", $time, obs_str()); end
            if (anode == 8'hFD) found = 1;
        end
        checks++; if (!found) begin fails++; $display("FAIL latch_wait_d1 got timeout want anode fd"); end
        value = 32'hFFFF_FFFF;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL latch_model2 @%0t %s", $time, obs_str()); end
            if (anode == 8'hFD) begin
                checks++; if (seg !== 7'h40) begin fails++; $display("FAIL latch_old_seg got %h want 40", seg); end
            end
            if (anode == 8'hFB) begin
                found = 1;
                checks++; if (seg !== 7'h0E) begin fails++; $display("FAIL latch_new_seg got %h want 0e", seg); end
            end
        end
        checks++; if (!found) begin fails++; $display("FAIL latch_wait_d2 got timeout want anode fb"); end
    endtask

    task automatic test_enable_drop();
        bit         found = 0;
        logic [2:0] saved;
        int         n = 0;
        value = $urandom; dp = 8'($urandom);
        for (int c = 0; c < 300 && !found; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL endrop_model @%0t %s", $time, obs_str()); end
            if (anode != 8'hFF) found = 1;
        end
        checks++; if (!found) begin fails++; $display("FAIL endrop_wait got timeout want lit"); end
        saved = digit_idx;
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL endrop_off_model @%0t %s", $time, obs_str()); end
            checks++; if (anode !== 8'hFF) begin fails++; $display("FAIL endrop_dark got %h want ff", anode); end
            checks++; if (digit_idx !== saved) begin fails++; $display("FAIL endrop_hold got %0d want %0d", digit_idx, saved); end
        end
        enable = 1'b1;
        found = 0;
        while (!found && n < 20) begin
            @(posedge clock); #1;
            n++;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL reen_model @%0t %s", $time, obs_str()); end
            if (anode != 8'hFF) found = 1;
        end
        checks++; if (n != BLANK + 1) begin fails++; $display("FAIL reen_latency got %0d want %0d", n, BLANK + 1); end
        checks++; if (digit_idx !== saved) begin fails++; $display("FAIL reen_digit got %0d want %0d", digit_idx, saved); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        // Mid-BLANK: restart scanning on digit 4 and reset two clocks in.
        digit_en = 8'h10; brightness = 4'hF;
        enable = 1'b0;
        @(posedge clock); #1;
        enable = 1'b1;
        repeat (2) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL rstb_model @%0t %s", $time, obs_str()); end
        end
        checks++; if (digit_idx !== 3'd4) begin fails++; $display("FAIL rstb_pre_idx got %0d want 4", digit_idx); end
        #2; reset = 1'b1; #1;
        checks++; if (w_obs !== {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin fails++; $display("FAIL rstb_values @%0t %s", $time, obs_str()); end
        @(posedge clock); #1;
        reset = 1'b0;
        // Mid-DRIVE: wait for the lit anode, then reset inside the cycle.
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL rstd_model @%0t %s", $time, obs_str()); end
            if (anode != 8'hFF) found = 1;
        end
        checks++; if (!found) begin fails++; $display("FAIL rstd_wait got timeout want lit"); end
        #2; reset = 1'b1; #1;
        checks++; if (w_obs !== {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin fails++; $display("FAIL rstd_values @%0t %s", $time, obs_str()); end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL rst_after_model @%0t %s", $time, obs_str()); end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            value = $urandom;
            dp = 8'($urandom);
            brightness = 4'($urandom);
            digit_en = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            enable = ($urandom_range(0, 5) != 0);
            for (int c = 0; c < int'($urandom_range(20, 90)); c++) begin
                @(posedge clock); #1;
                checks++; if (w_obs !== w_exp) begin fails++; $display("FAIL random_model @%0t %s", $time, obs_str()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_mask_skip();
        test_pwm();
        test_value_latch();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
